// File: rtl/smart_push_fifo.sv
// Multi-lane compacting FIFO. Sparse input lanes are packed into a circular buffer in lane order.
// The oldest entries are presented on dense output lanes, which drain in prefix order.
module smart_push_fifo #(
    parameter int INPUT_PORTS  = 4,
    parameter int OUTPUT_PORTS = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [INPUT_PORTS-1:0]               valid_in,
    input  logic [INPUT_PORTS*DATA_WIDTH-1:0]    data_in,
    output logic [INPUT_PORTS-1:0]               ready_out,
    output logic [OUTPUT_PORTS-1:0]              valid_out,
    output logic [OUTPUT_PORTS*DATA_WIDTH-1:0]   data_out,
    input  logic [OUTPUT_PORTS-1:0]              ready_in,
    output logic [$clog2(DEPTH):0]               count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         head_reg, head_next;
    logic [PW-1:0]         tail_reg, tail_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clear;
    logic [CW-1:0]         free;
    logic [CW-1:0]         rank [INPUT_PORTS];
    logic [PW-1:0]         wr_addr [INPUT_PORTS];
    logic [PW-1:0]         rd_addr [OUTPUT_PORTS];
    logic [INPUT_PORTS-1:0] accept;
    logic [CW-1:0]         push_cnt;
    logic [CW-1:0]         pop_cnt;

    assign clear = !rst_n || flush;

    // Room is judged from the registered count only, so pops never open space for same-cycle pushes.
    assign free = CW'(DEPTH) - count_reg;

    // Rank of each lane among the valid lanes below it; this is its slot offset from tail.
    always_comb begin : rank_walk
        logic [CW-1:0] run;
        run = '0;
        for (int i = 0; i < INPUT_PORTS; i++) begin
            rank[i] = run;
            if (valid_in[i]) begin
                run = run + CW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < INPUT_PORTS; gi++) begin : g_in_lane
            assign accept[gi]  = valid_in[gi] && (rank[gi] < free) && !clear;
            assign wr_addr[gi] = tail_reg + rank[gi][PW-1:0];
        end
    endgenerate

    assign ready_out = accept;

    always_comb begin : push_count
        push_cnt = '0;
        for (int i = 0; i < INPUT_PORTS; i++) begin
            if (accept[i]) begin
                push_cnt = push_cnt + CW'(1);
            end
        end
    end

    generate
        for (gi = 0; gi < OUTPUT_PORTS; gi++) begin : g_out_lane
            assign valid_out[gi] = CW'(gi) < count_reg;
            assign rd_addr[gi]   = head_reg + PW'(gi);
            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
                valid_out[gi] ? mem[rd_addr[gi]] : '0;
        end
    endgenerate

    // Only an unbroken run of taken lanes starting at lane 0 is popped.
    always_comb begin : pop_count
        logic stop;
        stop    = 1'b0;
        pop_cnt = '0;
        for (int j = 0; j < OUTPUT_PORTS; j++) begin
            if (!stop && valid_out[j] && ready_in[j]) begin
                pop_cnt = pop_cnt + CW'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (clear) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            head_next  = head_reg + pop_cnt[PW-1:0];
            tail_next  = tail_reg + push_cnt[PW-1:0];
            count_next = count_reg + push_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Accepted lanes occupy distinct slots, so several writes per cycle never collide.
    always_ff @(posedge clk) begin
        for (int i = 0; i < INPUT_PORTS; i++) begin
            if (accept[i]) begin
                mem[wr_addr[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_smart_push_fifo.sv
// Bench for smart_push_fifo: a queue model checked every cycle, plus directed literal checks.
module tb_smart_push_fifo;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [3:0]   valid_in;
    logic [127:0] data_in;
    logic [3:0]   ready_out;
    logic [1:0]   valid_out;
    logic [63:0]  data_out;
    logic [1:0]   ready_in;
    logic [3:0]   count;

    always #5 clk = ~clk;

    smart_push_fifo #(
        .INPUT_PORTS(4), .OUTPUT_PORTS(2), .DATA_WIDTH(32), .DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .ready_out(ready_out),
        .valid_out(valid_out), .data_out(data_out), .ready_in(ready_in),
        .count(count)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mq[$];
    logic [31:0] dlog[$];
    bit          chk_en    = 1'b0;
    bit          stream_en = 1'b0;
    int          max_seen  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [31:0] d);
        data_in[i*32 +: 32] = d;
    endtask

    // The first (8 - occupancy) valid lanes are the ones accepted.
    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        int k;
        int fr;
        r = 4'b0;
        if (rst_n && !flush) begin
            fr = 8 - mq.size();
            k  = 0;
            for (int i = 0; i < 4; i++) begin
                if (valid_in[i]) begin
                    if (k < fr) r[i] = 1'b1;
                    k++;
                end
            end
        end
        return r;
    endfunction

    // Model update: front of queue drains by the taken prefix, accepted lanes append in order.
    always @(posedge clk) begin
        logic [3:0]  acc;
        int          p;
        bit          stop;
        acc = exp_ready();
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            p    = 0;
            stop = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (!stop && j < mq.size() && ready_in[j]) p++;
                else stop = 1'b1;
            end
            for (int j = 0; j < p; j++) begin
                $display("pop  %h", mq[0]);
                void'(mq.pop_front());
            end
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    $display("push %h lane %0d", data_in[i*32 +: 32], i);
                    mq.push_back(data_in[i*32 +: 32]);
                end
            end
        end
        if (mq.size() > max_seen) max_seen = mq.size();
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        bit ev;
        bit stop;
        if (chk_en) begin
            chk("ready_out", 32'(ready_out), 32'(exp_ready()));
            for (int j = 0; j < 2; j++) begin
                ev = (j < mq.size());
                chk($sformatf("valid_out[%0d]", j), 32'(valid_out[j]), 32'(ev));
                chk($sformatf("data_out[%0d]", j), data_out[j*32 +: 32], ev ? mq[j] : 32'h0);
            end
            chk("count", 32'(count), 32'(mq.size()));
            if (stream_en) begin
                stop = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    if (!stop && valid_out[j] && ready_in[j]) dlog.push_back(data_out[j*32 +: 32]);
                    else stop = 1'b1;
                end
            end
        end
    end

    initial begin
        int nidx;
        int cyc;
        int r;
        int fr;
        logic [3:0] v;

        rst_n = 1'b0; flush = 1'b0; valid_in = '0; data_in = '0; ready_in = '0;
        tick();
        chk_en = 1'b1;
        tick();

        // Basic compaction
        rst_n = 1'b1;
        valid_in = 4'b1011;
        set_lane(0, 32'hA0); set_lane(1, 32'hA1); set_lane(2, 32'hEE); set_lane(3, 32'hA3);
        @(negedge clk);
        chk("reset_count", 32'(count), 32'd0);
        chk("compact_ready", 32'(ready_out), 32'h0000000B);
        tick();
        valid_in = '0;
        @(negedge clk);
        chk("compact_count", 32'(count), 32'd3);
        chk("compact_valid", 32'(valid_out), 32'd3);
        chk("compact_d0", data_out[31:0], 32'hA0);
        chk("compact_d1", data_out[63:32], 32'hA1);

        // Prefix pop
        ready_in = 2'b10;
        tick();
        ready_in = 2'b01;
        @(negedge clk);
        chk("gap_count", 32'(count), 32'd3);
        chk("gap_d0", data_out[31:0], 32'hA0);
        tick();
        ready_in = 2'b00;
        @(negedge clk);
        chk("pop1_count", 32'(count), 32'd2);
        chk("pop1_d0", data_out[31:0], 32'hA1);

        // Full / partial accept
        valid_in = 4'b1111;
        set_lane(0, 32'hC0); set_lane(1, 32'hC1); set_lane(2, 32'hC2); set_lane(3, 32'hC3);
        tick();
        set_lane(0, 32'hD0); set_lane(1, 32'hD1); set_lane(2, 32'hD2); set_lane(3, 32'hD3);
        ready_in = 2'b11;
        @(negedge clk);
        chk("partial_pre_count", 32'(count), 32'd6);
        chk("partial_ready", 32'(ready_out), 32'h3);
        tick();
        valid_in = '0;
        ready_in = 2'b01;
        @(negedge clk);
        chk("partial_count", 32'(count), 32'd6);
        chk("partial_d0", data_out[31:0], 32'hC0);
        tick();

        // Flush
        flush = 1'b1; valid_in = 4'b1111; ready_in = 2'b11;
        @(negedge clk);
        chk("flush_pre_count", 32'(count), 32'd5);
        chk("flush_ready", 32'(ready_out), 32'h0);
        tick();
        flush = 1'b0; valid_in = 4'b0001; set_lane(0, 32'hB0); ready_in = 2'b00;
        @(negedge clk);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(valid_out), 32'd0);
        tick();
        valid_in = '0;
        @(negedge clk);
        chk("after_flush_valid", 32'(valid_out), 32'd1);
        chk("after_flush_d0", data_out[31:0], 32'hB0);

        // Wrap-around stream of 0x00..0x13
        flush = 1'b1;
        tick();
        flush = 1'b0;
        dlog.delete();
        max_seen  = 0;
        stream_en = 1'b1;
        nidx = 0;
        cyc  = 0;
        while ((nidx < 20 || mq.size() > 0) && cyc < 300) begin
            v = '0; data_in = '0; r = 0;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 1) == 1 && nidx + r < 20) begin
                    v[i] = 1'b1;
                    set_lane(i, 32'(nidx + r));
                    r++;
                end
            end
            valid_in = v;
            ready_in = 2'($urandom_range(0, 3));
            fr = 8 - mq.size();
            tick();
            nidx += (r < fr) ? r : fr;
            cyc++;
        end
        valid_in = '0; ready_in = '0;
        stream_en = 1'b0;
        chk("stream_done_in_budget", 32'(cyc < 300), 32'd1);
        chk("stream_len", 32'(dlog.size()), 32'd20);
        for (int i = 0; i < 20 && i < dlog.size(); i++)
            chk($sformatf("stream_item[%0d]", i), dlog[i], 32'(i));
        chk("stream_max_le8", 32'(max_seen <= 8), 32'd1);

        // Mid-operation reset
        valid_in = 4'b1111;
        set_lane(0, 32'hE0); set_lane(1, 32'hE1); set_lane(2, 32'hE2); set_lane(3, 32'hE3);
        tick();
        valid_in = 4'b0111;
        set_lane(0, 32'hE4); set_lane(1, 32'hE5); set_lane(2, 32'hE6); set_lane(3, 32'hE7);
        tick();
        valid_in = 4'b1111; ready_in = 2'b11; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_pre_count", 32'(count), 32'd7);
        chk("rst_ready", 32'(ready_out), 32'h0);
        tick();
        rst_n = 1'b1; valid_in = '0; ready_in = '0;
        @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_d0", data_out[31:0], 32'h0);
        chk("rst_d1", data_out[63:32], 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
